gate_sweep_checker: RTL and testbench

Synthesisable, self-checking exhaustive sweeper for combinational gates, generalising the two-input AND truth-table bench to N inputs and six gate functions. It drives every input vector from 0 to 2^N_IN-1 onto a gate under test and holds each vector for a programmable settle time. It samples the gate output, compares it against an internal golden model, and reports pass/fail, an error count and the first failing vector. It sits beside any gate under test in a bench or on-chip self-test wrapper.

---
 rtl/gate_sweep_checker.sv | 146 ++++++++++++++
 tb/tb_gate_sweep_checker.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gate_sweep_checker.sv
// Exhaustive self-checking sweeper for an N_IN-input combinational gate.
// Steps every input vector, holds it SETTLE+1 cycles, and compares the gate output against a golden reduction.
module gate_sweep_checker #(
   parameter int unsigned N_IN   = 2,
   parameter int unsigned SETTLE = 1,
   parameter int unsigned ERR_W  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [2:0]        mode,
   input  logic              dut_y,
   output logic [N_IN-1:0]   vec_out,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [ERR_W-1:0]  err_count,
   output logic              first_err_valid,
   output logic [N_IN-1:0]   first_err_vec,
   output logic              mode_err
);

   localparam int unsigned CNT_W = 4;
   localparam logic [CNT_W-1:0] SETTLE_C = CNT_W'(SETTLE);

   localparam logic [2:0] MODE_AND  = 3'd0;
   localparam logic [2:0] MODE_OR   = 3'd1;
   localparam logic [2:0] MODE_XOR  = 3'd2;
   localparam logic [2:0] MODE_NAND = 3'd3;
   localparam logic [2:0] MODE_NOR  = 3'd4;
   localparam logic [2:0] MODE_MAX  = 3'd5;

   typedef enum logic {IDLE, SWEEP} state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [2:0]         mode_q, mode_d;
   logic [N_IN-1:0]    vec_d;
   logic               busy_d, done_d, pass_d, fev_d, merr_d;
   logic [ERR_W-1:0]   err_d;
   logic [N_IN-1:0]    fvec_d;
   logic               golden_c, mismatch_c;

   // Golden gate response for the vector currently driven
   always_comb begin
      golden_c = 1'b0;
      case (mode_q)
         MODE_AND:  golden_c = &vec_out;
         MODE_OR:   golden_c = |vec_out;
         MODE_XOR:  golden_c = ^vec_out;
         MODE_NAND: golden_c = ~(&vec_out);
         MODE_NOR:  golden_c = ~(|vec_out);
         default:   golden_c = ~(^vec_out);
      endcase
      mismatch_c = (dut_y != golden_c);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q         <= IDLE;
         cnt_q           <= '0;
         mode_q          <= '0;
         vec_out         <= '0;
         busy            <= 1'b0;
         done            <= 1'b0;
         pass            <= 1'b0;
         err_count       <= '0;
         first_err_valid <= 1'b0;
         first_err_vec   <= '0;
         mode_err        <= 1'b0;
      end else begin
         state_q         <= state_d;
         cnt_q           <= cnt_d;
         mode_q          <= mode_d;
         vec_out         <= vec_d;
         busy            <= busy_d;
         done            <= done_d;
         pass            <= pass_d;
         err_count       <= err_d;
         first_err_valid <= fev_d;
         first_err_vec   <= fvec_d;
         mode_err        <= merr_d;
      end
   end

   // Next-state and output logic; pulses default low, everything else holds
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      mode_d  = mode_q;
      vec_d   = vec_out;
      busy_d  = busy;
      done_d  = 1'b0;
      pass_d  = pass;
      err_d   = err_count;
      fev_d   = first_err_valid;
      fvec_d  = first_err_vec;
      merr_d  = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               if (mode <= MODE_MAX) begin
                  mode_d  = mode;
                  vec_d   = '0;
                  busy_d  = 1'b1;
                  err_d   = '0;
                  fev_d   = 1'b0;
                  fvec_d  = '0;
                  pass_d  = 1'b0;
                  cnt_d   = '0;
                  state_d = SWEEP;
               end else begin
                  merr_d = 1'b1;
               end
            end
         end
         SWEEP: begin
            if (cnt_q == SETTLE_C) begin
               cnt_d = '0;
               if (mismatch_c) begin
                  if (err_count != '1) err_d = err_count + ERR_W'(1);
                  if (!first_err_valid) begin
                     fev_d  = 1'b1;
                     fvec_d = vec_out;
                  end
               end
               // Terminal vector: pass must include this final compare
               if (vec_out == '1) begin
                  vec_d   = '0;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  pass_d  = !(first_err_valid || mismatch_c);
                  state_d = IDLE;
               end else begin
                  vec_d = vec_out + N_IN'(1);
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_gate_sweep_checker.sv
// Self-checking bench for gate_sweep_checker: table-driven and randomized sweeps against a truth-table model.
module tb_gate_sweep_checker;

   localparam int NM    = 3;
   localparam int SM    = 1;
   localparam int LAT_M = (1 << NM) * (SM + 1);

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // Main instance: N_IN=3, SETTLE=1, ERR_W=8; gate under test is a programmable truth table
   logic       start = 1'b0;
   logic [2:0] mode  = 3'd0;
   logic [7:0] tt    = 8'h80;
   logic       y;
   logic [2:0] vec, fvec;
   logic       busy, done, pass, fev, merr;
   logic [7:0] err;
   assign y = tt[vec];

   gate_sweep_checker #(.N_IN(3), .SETTLE(1), .ERR_W(8)) u_dut (
      .clk(clk), .rst(rst), .start(start), .mode(mode), .dut_y(y),
      .vec_out(vec), .busy(busy), .done(done), .pass(pass), .err_count(err),
      .first_err_valid(fev), .first_err_vec(fvec), .mode_err(merr));

   // Two-input ideal AND instance
   logic       start_t = 1'b0;
   logic       y_t;
   logic [1:0] vec_t, fvec_t;
   logic       busy_t, done_t, pass_t, fev_t, merr_t;
   logic [7:0] err_t;
   assign y_t = &vec_t;

   gate_sweep_checker #(.N_IN(2), .SETTLE(1), .ERR_W(8)) u_two (
      .clk(clk), .rst(rst), .start(start_t), .mode(3'd0), .dut_y(y_t),
      .vec_out(vec_t), .busy(busy_t), .done(done_t), .pass(pass_t), .err_count(err_t),
      .first_err_valid(fev_t), .first_err_vec(fvec_t), .mode_err(merr_t));

   // Saturation instance: 2-bit counter, OR gate stuck at 0
   logic       start_s = 1'b0;
   logic [2:0] vec_s, fvec_s;
   logic       busy_s, done_s, pass_s, fev_s, merr_s;
   logic [1:0] err_s;

   gate_sweep_checker #(.N_IN(3), .SETTLE(0), .ERR_W(2)) u_sat (
      .clk(clk), .rst(rst), .start(start_s), .mode(3'd1), .dut_y(1'b0),
      .vec_out(vec_s), .busy(busy_s), .done(done_s), .pass(pass_s), .err_count(err_s),
      .first_err_valid(fev_s), .first_err_vec(fvec_s), .mode_err(merr_s));

   typedef struct {
      logic [2:0] mode;
      logic [7:0] tt;
      int         exp_err;
      int         exp_fv;
      int         exp_fvec;
      int         exp_pass;
   } vec_rec_t;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   // Reference gate from the function's definition: count of ones in the vector
   function automatic bit gold(input int v, input int m);
      int ones;
      bit r;
      ones = $countones(v);
      case (m)
         0, 3:    r = (ones == NM);
         1, 4:    r = (ones != 0);
         default: r = (ones % 2 == 1);
      endcase
      return (m >= 3) ? !r : r;
   endfunction

   function automatic logic [7:0] ideal_tt(input int m);
      logic [7:0] t;
      for (int v = 0; v < 8; v++) t[v] = gold(v, m);
      return t;
   endfunction

   function automatic vec_rec_t model(input logic [2:0] m, input logic [7:0] t);
      vec_rec_t r;
      r.mode = m; r.tt = t; r.exp_err = 0; r.exp_fv = 0; r.exp_fvec = 0;
      for (int v = 0; v < 8; v++) begin
         if (t[v] != gold(v, int'(m))) begin
            if (r.exp_fv == 0) r.exp_fvec = v;
            r.exp_fv = 1;
            r.exp_err++;
         end
      end
      if (r.exp_err > 255) r.exp_err = 255;
      r.exp_pass = (r.exp_err == 0) ? 1 : 0;
      return r;
   endfunction

   task automatic start_sweep(input logic [2:0] m);
      @(negedge clk);
      start = 1'b1;
      mode  = m;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Called half a cycle after the accepting edge; start/mode are jittered while busy
   task automatic finish_sweep(input vec_rec_t r, input string nm);
      int  k;
      bit  seen;
      k = 0;
      seen = 0;
      chk({nm, "_busy0"}, 32'(busy), 32'd1);
      chk({nm, "_vec0"}, 32'(vec), 32'd0);
      while (!seen && k < LAT_M + 4) begin
         @(negedge clk);
         k++;
         if (done) seen = 1;
         else begin
            chk({nm, "_vecseq"}, 32'(vec), 32'(k / (SM + 1)));
            chk({nm, "_merr_busy"}, 32'(merr), 32'd0);
            start = 1'($urandom_range(0, 1));
            mode  = 3'($urandom_range(0, 7));
         end
      end
      start = 1'b0;
      chk({nm, "_latency"}, seen ? 32'(k) : 32'd0, 32'(LAT_M));
      chk({nm, "_err"}, 32'(err), 32'(r.exp_err));
      chk({nm, "_fv"}, 32'(fev), 32'(r.exp_fv));
      chk({nm, "_fvec"}, 32'(fvec), 32'(r.exp_fvec));
      chk({nm, "_pass"}, 32'(pass), 32'(r.exp_pass));
      chk({nm, "_busy_end"}, 32'(busy), 32'd0);
      chk({nm, "_vec_end"}, 32'(vec), 32'd0);
      @(negedge clk);
      chk({nm, "_done_pulse"}, 32'(done), 32'd0);
      chk({nm, "_hold_err"}, 32'(err), 32'(r.exp_err));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_rec_t tab[$];
      vec_rec_t last;
      vec_rec_t r;
      int k;
      int n_done;

      // Hand-derived expectations for N_IN=3
      tab.push_back('{3'd0, 8'h80, 0, 0, 0, 1});
      tab.push_back('{3'd2, 8'h00, 4, 1, 1, 0});
      tab.push_back('{3'd1, 8'h00, 7, 1, 1, 0});
      tab.push_back('{3'd3, 8'h7F, 0, 0, 0, 1});
      tab.push_back('{3'd4, 8'h01, 0, 0, 0, 1});
      tab.push_back('{3'd5, 8'h69, 0, 0, 0, 1});
      tab.push_back('{3'd3, 8'hFF, 1, 1, 7, 0});
      tab.push_back('{3'd0, 8'h81, 1, 1, 0, 0});
      for (int i = 0; i < 24; i++) begin
         logic [2:0] m;
         logic [7:0] t;
         m = 3'($urandom_range(0, 5));
         case ($urandom_range(0, 2))
            0:       t = ideal_tt(int'(m));
            1:       t = ideal_tt(int'(m)) ^ 8'(1 << $urandom_range(0, 7));
            default: t = 8'($urandom);
         endcase
         tab.push_back(model(m, t));
      end

      repeat (3) @(negedge clk);
      chk("rst_vec", 32'(vec), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_pass", 32'(pass), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_fv", 32'(fev), 32'd0);
      chk("rst_fvec", 32'(fvec), 32'd0);
      chk("rst_merr", 32'(merr), 32'd0);
      rst = 1'b0;

      // Two-input AND: vectors 00,01,10,11 each held two cycles, done 8 cycles after start
      @(negedge clk);
      start_t = 1'b1;
      @(negedge clk);
      start_t = 1'b0;
      chk("two_vec0", 32'(vec_t), 32'd0);
      k = 0;
      while (!done_t && k < 40) begin
         @(negedge clk);
         k++;
         if (!done_t) chk("two_vecseq", 32'(vec_t), 32'(k / 2));
      end
      chk("two_latency", 32'(k), 32'd8);
      chk("two_pass", 32'(pass_t), 32'd1);
      chk("two_err", 32'(err_t), 32'd0);
      chk("two_fv", 32'(fev_t), 32'd0);
      chk("two_fvec", 32'(fvec_t), 32'd0);
      chk("two_busy", 32'(busy_t), 32'd0);
      chk("two_merr", 32'(merr_t), 32'd0);

      // Saturating counter: 7 mismatches clip at 3
      @(negedge clk);
      start_s = 1'b1;
      @(negedge clk);
      start_s = 1'b0;
      k = 0;
      while (!done_s && k < 40) begin
         @(negedge clk);
         k++;
      end
      chk("sat_latency", 32'(k), 32'd8);
      chk("sat_err", 32'(err_s), 32'd3);
      chk("sat_fv", 32'(fev_s), 32'd1);
      chk("sat_fvec", 32'(fvec_s), 32'd1);
      chk("sat_pass", 32'(pass_s), 32'd0);
      chk("sat_vec", 32'(vec_s), 32'd0);
      chk("sat_busy", 32'(busy_s), 32'd0);
      chk("sat_merr", 32'(merr_s), 32'd0);

      foreach (tab[i]) begin
         tt = tab[i].tt;
         start_sweep(tab[i].mode);
         finish_sweep(tab[i], $sformatf("sweep%0d_m%0d_tt%02h", i, tab[i].mode, tab[i].tt));
      end
      last = tab[tab.size() - 1];

      // Reserved modes pulse mode_err and leave results untouched
      for (int m = 6; m < 8; m++) begin
         start_sweep(3'(m));
         chk($sformatf("merr%0d_pulse", m), 32'(merr), 32'd1);
         chk($sformatf("merr%0d_busy", m), 32'(busy), 32'd0);
         chk($sformatf("merr%0d_vec", m), 32'(vec), 32'd0);
         chk($sformatf("merr%0d_err", m), 32'(err), 32'(last.exp_err));
         chk($sformatf("merr%0d_pass", m), 32'(pass), 32'(last.exp_pass));
         @(negedge clk);
         chk($sformatf("merr%0d_clear", m), 32'(merr), 32'd0);
      end

      // start held high, mode changed mid-sweep; restart on the done cycle
      tt = 8'h80;
      @(negedge clk);
      start = 1'b1;
      mode  = 3'd0;
      k = 0;
      @(negedge clk);
      while (!done && k < 40) begin
         @(negedge clk);
         k++;
         if (k == 5) mode = 3'd2;
      end
      chk("held_latency", 32'(k), 32'(LAT_M));
      chk("held_pass", 32'(pass), 32'd1);
      chk("held_err", 32'(err), 32'd0);
      @(negedge clk);
      start = 1'b0;
      chk("restart_busy", 32'(busy), 32'd1);
      chk("restart_err_clr", 32'(err), 32'd0);
      chk("restart_pass_clr", 32'(pass), 32'd0);
      chk("restart_done", 32'(done), 32'd0);
      finish_sweep('{3'd2, 8'h80, 3, 1, 1, 0}, "restart_xor");

      // Reset mid-sweep at vector 2 with an error already logged
      tt = 8'h81;
      start_sweep(3'd0);
      k = 0;
      while (vec != 3'd2 && k < 40) begin
         @(negedge clk);
         k++;
      end
      chk("mid_reach_v2", 32'(vec), 32'd2);
      chk("mid_err_before", 32'(err), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("mid_rst_vec", 32'(vec), 32'd0);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_done", 32'(done), 32'd0);
      chk("mid_rst_pass", 32'(pass), 32'd0);
      chk("mid_rst_err", 32'(err), 32'd0);
      chk("mid_rst_fv", 32'(fev), 32'd0);
      chk("mid_rst_fvec", 32'(fvec), 32'd0);
      chk("mid_rst_merr", 32'(merr), 32'd0);
      n_done = 0;
      repeat (LAT_M + 4) begin
         @(negedge clk);
         if (done) n_done++;
      end
      chk("mid_no_done", 32'(n_done), 32'd0);
      tt = 8'h80;
      start_sweep(3'd0);
      r = '{3'd0, 8'h80, 0, 0, 0, 1};
      finish_sweep(r, "post_rst_clean");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
